fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the 8-bit asynchronous FIFO among several producers in the write-clock domain. It grants one requester at a time for a bounded burst, applies FIFO back-pressure through per-requester ready signals, and drives the FIFO's write-enable and write-data inputs directly. It sits between the producer blocks and the FIFO write side.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, data width, matches FIFO write data
- MAX_BURST, 4, max beats per grant (≥1)

- CLK_top  in  1  write-domain clock, same clock as the FIFO write port
- RST_top  in  1  reset, asynchronous, active-low
- REQ_VALID  in  NUM_REQ  per-requester data valid
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- REQ_READY  out  NUM_REQ  per-requester accept; beat transfers when VALID&READY
- FULL_in  in  1  FIFO full flag, write domain
- WRITE_ENABLE  out  1  to FIFO write enable
- WRITE_DATA_OUT  out  DATA_WIDTH  to FIFO write data
- GRANT  out  NUM_REQ  one-hot current owner, all-zero in IDLE
- BUSY  out  1  high in BURST state

## Operation
- States: IDLE, BURST. Registers: state, GRANT, last-grant index, beat counter (clog2(MAX_BURST+1) bits).
- IDLE: if any REQ_VALID high, choose first valid index searching upward from last+1, modulo NUM_REQ; register GRANT one-hot, last := chosen, beat := 0, go BURST. No valid → stay IDLE.
- BURST, combinational: REQ_READY[g] = GRANT[g] & ~FULL_in; all other READY bits 0. xfer = REQ_VALID[g] & REQ_READY[g].
- WRITE_ENABLE = xfer; WRITE_DATA_OUT = REQ_DATA slice of g when xfer, else 0. No register stage: FIFO samples on the same edge.
- On xfer: beat := beat+1. If beat+1 == MAX_BURST → release.
- If REQ_VALID[g] low in a cycle → release (regardless of FULL_in).
- FULL_in high with REQ_VALID[g] high: stall; no xfer, beat unchanged, grant held indefinitely.
- Release: GRANT := 0, go IDLE. Exactly one IDLE cycle between bursts (no back-to-back regrant).
- Requesters not granted see READY=0 and must hold data; arbiter never drops or duplicates a beat.

## Timing
- Reset (RST_top low, async): state=IDLE, GRANT=0, last=NUM_REQ-1 (requester 0 has first priority), beat=0, BUSY=0; REQ_READY=0, WRITE_ENABLE=0, WRITE_DATA_OUT=0 immediately.
- Reset released mid-burst: no write after reset assertion; first grant after release follows post-reset priority.
- Request-to-first-write latency: REQ_VALID seen high at edge N in IDLE → GRANT/BUSY high after edge N, first WRITE_ENABLE in cycle N+1 (if FULL_in low).
- Full burst occupies MAX_BURST cycles plus one IDLE cycle; peak throughput MAX_BURST/(MAX_BURST+1).
- FULL_in → REQ_READY/WRITE_ENABLE: combinational, zero cycles.
- Pointer wrap: last=NUM_REQ-1 searches from 0.
- Single requester continuously valid: regranted every MAX_BURST+1 cycles.

## Test plan
- Reset: hold RST_top low with all REQ_VALID=4'b1111 → GRANT=0, WRITE_ENABLE=0, REQ_READY=0; after release first GRANT=4'b0001.
- Round-robin: all four valid, data 8'h10+i per requester, FULL_in=0 → grants 0,1,2,3,0 in order, each exactly 4 writes, one idle cycle between, FIFO receives 8'h10×4, 8'h11×4, 8'h12×4, 8'h13×4.
- Short burst: requester 2 only, valid for 2 beats (8'hA1, 8'hA2) → 2 writes, release on VALID low, GRANT back to 0.
- Back-pressure: requester 1 granted, FULL_in high for 3 cycles after beat 1 → REQ_READY[1]=0, WRITE_ENABLE=0 for those 3 cycles, grant held, beat count resumes, total 4 writes, no duplicate.
- Wrap/priority: last grant=3, requesters 0 and 3 valid → requester 0 granted next.
- Scoreboard: random valid/FULL_in over 1000 cycles → FIFO write sequence equals per-requester accepted beats in order; GRANT always one-hot or zero; WRITE_ENABLE never high with FULL_in high.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the async FIFO write port; grant registered one cycle after request, writes pass through combinationally.
// FULL_in stalls the owner with zero-cycle READY/WRITE_ENABLE deassertion; non-owners always see READY low.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLK_top,
  input  logic                          RST_top,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FULL_in,
  output logic                          WRITE_ENABLE,
  output logic [DATA_WIDTH-1:0]         WRITE_DATA_OUT,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          BUSY
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic [BEAT_W-1:0]   beat;
  logic                pick_vld;
  logic                owner_vld;
  logic                xfer;
  logic                last_beat;
  logic [DATA_WIDTH-1:0] req_dat [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_dat[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search upward from the previous owner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_idx;
    cand_idx = last_idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      if (!pick_vld && REQ_VALID[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // last_idx always names the current owner while in BURST.
  assign owner_vld      = (state == BURST) && REQ_VALID[last_idx];
  assign xfer           = owner_vld && !FULL_in;
  assign last_beat      = (beat == BEAT_W'(MAX_BURST - 1));
  assign REQ_READY      = GRANT & {NUM_REQ{~FULL_in}};
  assign WRITE_ENABLE   = xfer;
  assign WRITE_DATA_OUT = xfer ? req_dat[last_idx] : '0;

  always_ff @(posedge CLK_top or negedge RST_top) begin
    if (!RST_top) begin
      state    <= IDLE;
      GRANT    <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
      beat     <= '0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= BURST;
            GRANT    <= NUM_REQ'(1) << pick_idx;
            last_idx <= pick_idx;
            beat     <= '0;
            BUSY     <= 1'b1;
          end
        end
        BURST: begin
          // A stalled owner keeps the grant; a dropped valid or final beat releases it.
          if (!owner_vld || (xfer && last_beat)) begin
            state <= IDLE;
            GRANT <= '0;
            beat  <= '0;
            BUSY  <= 1'b0;
          end else if (xfer) begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          GRANT <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             CLK_top = 1'b0;
  logic             RST_top = 1'b0;
  logic [NR-1:0]    REQ_VALID = '0;
  logic [NR*DW-1:0] REQ_DATA = '0;
  logic [NR-1:0]    REQ_READY;
  logic             FULL_in = 1'b0;
  logic             WRITE_ENABLE;
  logic [DW-1:0]    WRITE_DATA_OUT;
  logic [NR-1:0]    GRANT;
  logic             BUSY;

  int n_cmp = 0;
  int n_err = 0;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK_top(CLK_top), .RST_top(RST_top), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .FULL_in(FULL_in), .WRITE_ENABLE(WRITE_ENABLE),
    .WRITE_DATA_OUT(WRITE_DATA_OUT), .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 CLK_top = ~CLK_top;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic set_data(input int i, input logic [DW-1:0] d);
    REQ_DATA[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    RST_top = 1'b0; REQ_VALID = '0; FULL_in = 1'b0; REQ_DATA = '0;
    repeat (2) @(posedge CLK_top);
    #1 RST_top = 1'b1;
  endtask

  task automatic test_reset();
    FULL_in = 1'b0; REQ_VALID = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));
    RST_top = 1'b0;
    repeat (2) begin
      @(negedge CLK_top);
      n_cmp++;
      if ({GRANT, REQ_READY, WRITE_ENABLE, BUSY, WRITE_DATA_OUT} !== '0) begin
        n_err++;
        $display("FAIL reset_hold: grant=%b ready=%b we=%b busy=%b data=%h, want all zero",
                 GRANT, REQ_READY, WRITE_ENABLE, BUSY, WRITE_DATA_OUT);
      end
    end
    @(posedge CLK_top); #1 RST_top = 1'b1;
    @(negedge CLK_top);
    n_cmp++;
    if (GRANT !== 4'b0000) begin n_err++; $display("FAIL reset_idle_grant: got %b want 0000", GRANT); end
    @(negedge CLK_top);
    n_cmp++;
    if ({GRANT, BUSY, WRITE_ENABLE, WRITE_DATA_OUT} !== {4'b0001, 1'b1, 1'b1, 8'h10}) begin
      n_err++;
      $display("FAIL reset_first_grant: grant=%b busy=%b we=%b data=%h want 0001 1 1 10",
               GRANT, BUSY, WRITE_ENABLE, WRITE_DATA_OUT);
    end
    // Assert reset mid-burst, away from any clock edge.
    @(posedge CLK_top); #3 RST_top = 1'b0;
    #1;
    n_cmp++;
    if ({GRANT, REQ_READY, WRITE_ENABLE, BUSY, WRITE_DATA_OUT} !== '0) begin
      n_err++;
      $display("FAIL reset_async: grant=%b ready=%b we=%b busy=%b data=%h want all zero",
               GRANT, REQ_READY, WRITE_ENABLE, BUSY, WRITE_DATA_OUT);
    end
    @(negedge CLK_top);
    n_cmp++;
    if (WRITE_ENABLE !== 1'b0) begin n_err++; $display("FAIL reset_no_write: we=%b want 0", WRITE_ENABLE); end
    @(posedge CLK_top); #1 RST_top = 1'b1;
    @(negedge CLK_top);
    @(negedge CLK_top);
    n_cmp++;
    if (GRANT !== 4'b0001) begin n_err++; $display("FAIL reset_post_priority: grant=%b want 0001", GRANT); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] eg;
    logic          ew;
    logic [DW-1:0] ed;
    do_reset();
    for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));
    REQ_VALID = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK_top);
      if (c % 5 == 0) begin
        eg = '0; ew = 1'b0; ed = '0;
      end else begin
        eg = NR'(1) << ((c / 5) % NR);
        ew = 1'b1;
        ed = 8'(8'h10 + (c / 5) % NR);
      end
      n_cmp++;
      if (GRANT !== eg) begin n_err++; $display("FAIL rr_grant c=%0d: got %b want %b", c, GRANT, eg); end
      n_cmp++;
      if (WRITE_ENABLE !== ew) begin n_err++; $display("FAIL rr_we c=%0d: got %b want %b", c, WRITE_ENABLE, ew); end
      n_cmp++;
      if (WRITE_DATA_OUT !== ed) begin n_err++; $display("FAIL rr_data c=%0d: got %h want %h", c, WRITE_DATA_OUT, ed); end
    end
    REQ_VALID = '0;
  endtask

  task automatic test_short_burst();
    logic [NR-1:0] eg [5];
    logic          ew [5];
    logic [DW-1:0] ed [5];
    int writes;
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ed = '{8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00};
    writes = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge CLK_top); #1; end
      REQ_VALID = (c < 3) ? 4'b0100 : 4'b0000;
      set_data(2, (c >= 2) ? 8'hA2 : 8'hA1);
      @(negedge CLK_top);
      if (WRITE_ENABLE === 1'b1) writes++;
      n_cmp++;
      if ({GRANT, BUSY, WRITE_ENABLE, WRITE_DATA_OUT} !== {eg[c], (eg[c] != '0), ew[c], ed[c]}) begin
        n_err++;
        $display("FAIL short_cycle c=%0d: grant=%b busy=%b we=%b data=%h want %b %b %b %h",
                 c, GRANT, BUSY, WRITE_ENABLE, WRITE_DATA_OUT, eg[c], (eg[c] != '0), ew[c], ed[c]);
      end
    end
    n_cmp++;
    if (writes != 2) begin n_err++; $display("FAIL short_writes: got %0d want 2", writes); end
  endtask

  task automatic test_back_pressure();
    logic [NR-1:0] eg, er;
    logic          ew;
    logic [DW-1:0] ed;
    int acc, writes;
    acc = 0; writes = 0;
    do_reset();
    REQ_VALID = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin @(posedge CLK_top); #1; end
      FULL_in = (c >= 2 && c <= 4);
      set_data(1, 8'(8'hB0 + acc));
      @(negedge CLK_top);
      eg = (c >= 1 && c <= 7) ? 4'b0010 : 4'b0000;
      er = FULL_in ? 4'b0000 : eg;
      ew = (c == 1 || c == 5 || c == 6 || c == 7);
      ed = ew ? 8'(8'hB0 + acc) : 8'h00;
      if (WRITE_ENABLE === 1'b1) writes++;
      n_cmp++;
      if (GRANT !== eg) begin n_err++; $display("FAIL bp_grant c=%0d: got %b want %b", c, GRANT, eg); end
      n_cmp++;
      if (REQ_READY !== er) begin n_err++; $display("FAIL bp_ready c=%0d: got %b want %b", c, REQ_READY, er); end
      n_cmp++;
      if ({WRITE_ENABLE, WRITE_DATA_OUT} !== {ew, ed}) begin
        n_err++;
        $display("FAIL bp_write c=%0d: we=%b data=%h want %b %h", c, WRITE_ENABLE, WRITE_DATA_OUT, ew, ed);
      end
      if (ew) acc++;
    end
    n_cmp++;
    if (writes != 4) begin n_err++; $display("FAIL bp_total_writes: got %0d want 4", writes); end
    REQ_VALID = '0; FULL_in = 1'b0;
  endtask

  task automatic test_wrap();
    logic [NR-1:0] eg;
    logic          ew;
    logic [DW-1:0] ed;
    do_reset();
    set_data(0, 8'h5A); set_data(3, 8'hC3);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge CLK_top); #1; end
      REQ_VALID = (c == 0) ? 4'b1000 : 4'b1001;
      @(negedge CLK_top);
      eg = (c >= 1 && c <= 4) ? 4'b1000 : (c == 6) ? 4'b0001 : 4'b0000;
      ew = (eg != '0);
      ed = (c == 6) ? 8'h5A : ew ? 8'hC3 : 8'h00;
      n_cmp++;
      if ({GRANT, REQ_READY} !== {eg, eg}) begin
        n_err++;
        $display("FAIL wrap_grant c=%0d: grant=%b ready=%b want %b %b", c, GRANT, REQ_READY, eg, eg);
      end
      n_cmp++;
      if ({WRITE_ENABLE, WRITE_DATA_OUT} !== {ew, ed}) begin
        n_err++;
        $display("FAIL wrap_write c=%0d: we=%b data=%h want %b %h", c, WRITE_ENABLE, WRITE_DATA_OUT, ew, ed);
      end
    end
    REQ_VALID = '0;
  endtask

  task automatic test_random();
    int owner, last, cnt;
    logic [DW-1:0] cur [NR];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] obs_q [$];
    logic [NR-1:0] eg, er;
    logic          ex;
    logic [DW-1:0] ed;
    int shown;
    owner = -1; last = NR - 1; cnt = 0; shown = 0;
    for (int i = 0; i < NR; i++) cur[i] = 8'($urandom);
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc > 0) begin @(posedge CLK_top); #1; end
      for (int i = 0; i < NR; i++) begin
        REQ_VALID[i] = ($urandom_range(0, 9) < 7);
        set_data(i, cur[i]);
      end
      FULL_in = ($urandom_range(0, 3) == 0);
      @(negedge CLK_top);
      eg = (owner >= 0) ? NR'(1) << owner : '0;
      er = FULL_in ? '0 : eg;
      ex = (owner >= 0) && REQ_VALID[owner] && !FULL_in;
      ed = ex ? cur[owner] : '0;
      n_cmp++;
      if (GRANT !== eg) begin n_err++; $display("FAIL rnd_grant cyc=%0d: got %b want %b", cyc, GRANT, eg); end
      n_cmp++;
      if (REQ_READY !== er) begin n_err++; $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, REQ_READY, er); end
      n_cmp++;
      if ({WRITE_ENABLE, WRITE_DATA_OUT} !== {ex, ed}) begin
        n_err++;
        $display("FAIL rnd_write cyc=%0d: we=%b data=%h want %b %h", cyc, WRITE_ENABLE, WRITE_DATA_OUT, ex, ed);
      end
      n_cmp++;
      if (!$onehot0(GRANT) || (WRITE_ENABLE && FULL_in)) begin
        n_err++;
        $display("FAIL rnd_invariant cyc=%0d: grant=%b we=%b full=%b", cyc, GRANT, WRITE_ENABLE, FULL_in);
      end
      if (WRITE_ENABLE === 1'b1) obs_q.push_back(WRITE_DATA_OUT);
      if (ex) exp_q.push_back(cur[owner]);
      // Reference arbitration rules applied at the coming edge.
      if (owner < 0) begin
        for (int k = 1; k <= NR; k++) begin
          if (owner < 0 && REQ_VALID[(last + k) % NR]) begin
            owner = (last + k) % NR; last = owner; cnt = 0;
          end
        end
      end else if (!REQ_VALID[owner]) begin
        owner = -1;
      end else if (!FULL_in) begin
        cnt++;
        cur[owner] = 8'($urandom);
        if (cnt == MB) owner = -1;
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL rnd_stream_len: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end else begin
      n_cmp++;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          if (shown == 0) begin
            n_err++;
            $display("FAIL rnd_stream idx=%0d: got %h want %h", i, obs_q[i], exp_q[i]);
          end
          shown++;
        end
      end
    end
    REQ_VALID = '0; FULL_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_short_burst();
    test_back_pressure();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
